// File: rtl/clock_set_controller.sv
// clock_set_controller: sequencing controller for the time_register datapath.
// Cascades the 1 Hz tick into second/minute/hour increments in RUN, runs the
// RUN -> SET_HOURS -> SET_MINUTES time-setting machine with adjust auto-repeat,
// drives the blink blanking of the field being set and issues the one-shot
// initial load after reset.
//
// Optional feature macro: CLOCK_SET_TIMEOUT_EN (abandon set mode after
// TIMEOUT_TICKS idle seconds). Undefined by default: set states persist.
//
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   tick_1hz                    one-cycle pulse per second
//   btn_mode                    one-cycle pulse, advances the set-mode state
//   btn_adjust                  level, high while adjust button is held
//   will_wraparound_*           field-at-maximum flags from time_register
//   time_to_load_bcd            constant INIT_TIME_BCD
//   load_new                    registered one-shot load strobe
//   increment_{hours,minutes,seconds}  combinational increment strobes
//   blank_{hours,minutes}       registered blink blanking
//   set_mode                    registered: 0 RUN, 1 SET_HOURS, 2 SET_MINUTES
module clock_set_controller #(
    parameter logic [23:0] INIT_TIME_BCD = 24'h12_00_00,
    parameter logic [23:0] REPEAT_DELAY  = 24'd500000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd100000,
    parameter logic [23:0] BLINK_HALF    = 24'd250000,
    parameter int unsigned TIMEOUT_TICKS = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1hz,
    input  logic        btn_mode,
    input  logic        btn_adjust,
    input  logic        will_wraparound_hours,
    input  logic        will_wraparound_minutes,
    input  logic        will_wraparound_seconds,
    output logic [23:0] time_to_load_bcd,
    output logic        load_new,
    output logic        increment_hours,
    output logic        increment_minutes,
    output logic        increment_seconds,
    output logic        blank_hours,
    output logic        blank_minutes,
    output logic [1:0]  set_mode
);

    localparam int unsigned CNT_W = 24;
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_TICKS);

    typedef enum logic [1:0] {
        ST_RUN         = 2'd0,
        ST_SET_HOURS   = 2'd1,
        ST_SET_MINUTES = 2'd2
    } state_t;

    state_t           state_q, state_nxt;
    logic             adj_q;
    logic             rep_active_q;
    logic [CNT_W-1:0] rep_cnt_q;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_nxt, blink_inc;
    logic             phase_q, phase_nxt;
    logic             loaded_q;
    logic [CNT_W-1:0] idle_cnt_q;

    logic adj_rise, rep_fire, adj_evt, adj_ok, timeout, blink_clr;
    logic in_run, inc_gate;

    // Hour wrap is handled entirely inside time_register.
    logic unused_wrap_hours;
    assign unused_wrap_hours = will_wraparound_hours;

    assign time_to_load_bcd = INIT_TIME_BCD;
    assign set_mode         = state_q;

    // Adjust events, next state, blink and increment decode.
    always_comb begin
        adj_rise      = btn_adjust & ~adj_q;
        rep_fire      = 1'b0;
        state_nxt     = state_q;
        blink_inc     = blink_cnt_q + CNT_W'(1);
        blink_cnt_nxt = blink_inc;
        phase_nxt     = phase_q;

        if (rep_active_q)
            rep_fire = btn_adjust & adj_q & (rep_cnt_q >= REPEAT_PERIOD);
        else
            rep_fire = btn_adjust & adj_q & (rep_cnt_q >= REPEAT_DELAY);
        adj_evt = adj_rise | rep_fire;

        // A mode press in the same cycle swallows the adjust event.
        adj_ok  = adj_evt & ~btn_mode & (state_q != ST_RUN);
        timeout = (state_q != ST_RUN) & (idle_cnt_q != '0) & (idle_cnt_q >= TIMEOUT_LIM);

        if (btn_mode) begin
            case (state_q)
                ST_RUN:       state_nxt = ST_SET_HOURS;
                ST_SET_HOURS: state_nxt = ST_SET_MINUTES;
                default:      state_nxt = ST_RUN;
            endcase
        end else if (timeout) begin
            state_nxt = ST_RUN;
        end

        // Keep digits visible right after any adjust or state change.
        blink_clr = adj_ok | btn_mode | timeout;
        if (blink_clr) begin
            blink_cnt_nxt = '0;
            phase_nxt     = 1'b0;
        end else if (blink_inc >= BLINK_HALF) begin
            blink_cnt_nxt = '0;
            phase_nxt     = ~phase_q;
        end

        in_run            = (state_q == ST_RUN);
        inc_gate          = ~reset & ~load_new;
        increment_seconds = inc_gate & in_run & tick_1hz;
        increment_minutes = inc_gate & (in_run ? (tick_1hz & will_wraparound_seconds)
                                               : ((state_q == ST_SET_MINUTES) & adj_ok));
        increment_hours   = inc_gate & (in_run ? (tick_1hz & will_wraparound_seconds &
                                                  will_wraparound_minutes)
                                               : ((state_q == ST_SET_HOURS) & adj_ok));
    end

    // State, repeat timer, blink timer, load strobe and blanking registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            adj_q         <= 1'b0;
            rep_active_q  <= 1'b0;
            rep_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            phase_q       <= 1'b0;
            blank_hours   <= 1'b0;
            blank_minutes <= 1'b0;
            load_new      <= 1'b0;
            loaded_q      <= 1'b0;
        end else begin
            state_q <= state_nxt;
            adj_q   <= btn_adjust;

            // Repeat timing follows the button only, independent of mode.
            if (!btn_adjust) begin
                rep_cnt_q    <= '0;
                rep_active_q <= 1'b0;
            end else if (rep_fire) begin
                rep_cnt_q    <= CNT_W'(1);
                rep_active_q <= 1'b1;
            end else begin
                rep_cnt_q    <= rep_cnt_q + CNT_W'(1);
            end

            blink_cnt_q   <= blink_cnt_nxt;
            phase_q       <= phase_nxt;
            blank_hours   <= (state_nxt == ST_SET_HOURS) & phase_nxt;
            blank_minutes <= (state_nxt == ST_SET_MINUTES) & phase_nxt;

            load_new <= ~loaded_q;
            loaded_q <= 1'b1;
        end
    end

`ifdef CLOCK_SET_TIMEOUT_EN
    // Idle seconds spent in a set state without any button activity.
    always_ff @(posedge clk) begin
        if (reset)
            idle_cnt_q <= '0;
        else if (in_run || btn_mode || adj_ok)
            idle_cnt_q <= '0;
        else if (tick_1hz && (idle_cnt_q != '1))
            idle_cnt_q <= idle_cnt_q + CNT_W'(1);
    end
`else
    assign idle_cnt_q = '0;
`endif

endmodule

// File: tb/tb_clock_set_controller.sv
module tb_clock_set_controller;

    localparam logic [23:0] INIT = 24'h12_00_00;
    localparam logic [23:0] RD   = 24'd10;
    localparam logic [23:0] RP   = 24'd4;
    localparam logic [23:0] BH   = 24'd5;
    localparam int unsigned TT   = 3;
`ifdef CLOCK_SET_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk;
    logic        reset, tick_1hz, btn_mode, btn_adjust;
    logic        wrap_h, wrap_m, wrap_s;
    logic [23:0] time_to_load_bcd;
    logic        load_new, increment_hours, increment_minutes, increment_seconds;
    logic        blank_hours, blank_minutes;
    logic [1:0]  set_mode;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: wall-clock time plus controller view of the spec.
    int m_hh = 0, m_mm = 0, m_ss = 0;
    bit m_load = 0, m_loaded = 0;
    int m_mode = 0;   // 0 RUN, 1 SET_HOURS, 2 SET_MINUTES
    int m_age = 0;    // cycles btn_adjust has already been high
    int m_bk = 1;     // cycles since the blink was last restarted, from 1
    int m_idle = 0;   // idle ticks in a set state

    int cnt_h = 0, cnt_m = 0, cnt_s = 0;
    int ev_q[$];
    int ev_base = 0;
    bit rec_ev = 0;

    assign wrap_h = (m_hh == 23);
    assign wrap_m = (m_mm == 59);
    assign wrap_s = (m_ss == 59);

    clock_set_controller #(
        .INIT_TIME_BCD(INIT), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
        .BLINK_HALF(BH), .TIMEOUT_TICKS(TT)
    ) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .btn_mode(btn_mode),
        .btn_adjust(btn_adjust), .will_wraparound_hours(wrap_h),
        .will_wraparound_minutes(wrap_m), .will_wraparound_seconds(wrap_s),
        .time_to_load_bcd(time_to_load_bcd), .load_new(load_new),
        .increment_hours(increment_hours), .increment_minutes(increment_minutes),
        .increment_seconds(increment_seconds), .blank_hours(blank_hours),
        .blank_minutes(blank_minutes), .set_mode(set_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Adjust event from press age: press, then DELAY, then every PERIOD.
    function automatic bit m_evt();
        int d, p;
        d = (RD == 0) ? 1 : int'(RD);
        p = (RP == 0) ? 1 : int'(RP);
        if (!btn_adjust) return 1'b0;
        if (m_age == 0) return 1'b1;
        return (m_age >= d) && (((m_age - d) % p) == 0);
    endfunction

    function automatic bit m_phase();
        int bh;
        bh = (BH == 0) ? 1 : int'(BH);
        return (((m_bk - 1) / bh) % 2) == 1;
    endfunction

    // Expected {hours, minutes, seconds} increments for the current inputs.
    function automatic logic [2:0] m_inc();
        bit adj;
        if (reset || m_load) return 3'b000;
        if (m_mode == 0) return {tick_1hz & wrap_s & wrap_m, tick_1hz & wrap_s, tick_1hz};
        adj = m_evt() && !btn_mode;
        return {adj && (m_mode == 1), adj && (m_mode == 2), 1'b0};
    endfunction

    task automatic compare_all();
        logic [2:0] ei;
        ei = m_inc();
        chk("load_new", 32'(load_new), 32'(m_load));
        chk("time_to_load_bcd", 32'(time_to_load_bcd), 32'(INIT));
        chk("set_mode", 32'(set_mode), 32'(m_mode));
        chk("blank_hours", 32'(blank_hours), 32'((m_mode == 1) && m_phase()));
        chk("blank_minutes", 32'(blank_minutes), 32'((m_mode == 2) && m_phase()));
        chk("increment_hours", 32'(increment_hours), 32'(ei[2]));
        chk("increment_minutes", 32'(increment_minutes), 32'(ei[1]));
        chk("increment_seconds", 32'(increment_seconds), 32'(ei[0]));
    endtask

    task automatic model_advance();
        logic [2:0] ei;
        bit adj_ok, tmo;
        int tlim;
        ei = m_inc();
        if (ei[0]) m_ss = (m_ss + 1) % 60;
        if (ei[1]) m_mm = (m_mm + 1) % 60;
        if (ei[2]) m_hh = (m_hh + 1) % 24;
        if (m_load) begin m_hh = 12; m_mm = 0; m_ss = 0; end
        if (reset) begin
            m_load = 0; m_loaded = 0; m_mode = 0; m_age = 0; m_bk = 1; m_idle = 0;
        end else begin
            adj_ok = m_evt() && !btn_mode && (m_mode != 0);
            tlim = (TT == 0) ? 1 : int'(TT);
            tmo = TMO_EN && (m_mode != 0) && (m_idle >= tlim);
            m_bk = (btn_mode || tmo || adj_ok) ? 1 : m_bk + 1;
            if (btn_mode || adj_ok || m_mode == 0) m_idle = 0;
            else if (tick_1hz) m_idle++;
            m_age = btn_adjust ? m_age + 1 : 0;
            if (btn_mode) m_mode = (m_mode + 1) % 3;
            else if (tmo) m_mode = 0;
            m_load = !m_loaded;
            m_loaded = 1;
        end
    endtask

    // One clock: compare and observe mid-cycle, advance model, step past the edge.
    task automatic cycle();
        @(negedge clk);
        compare_all();
        if (increment_hours) cnt_h++;
        if (increment_minutes) cnt_m++;
        if (increment_seconds) cnt_s++;
        if (rec_ev && increment_minutes) ev_q.push_back(cyc - ev_base);
        model_advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clr_cnt();
        cnt_h = 0; cnt_m = 0; cnt_s = 0;
    endtask

    logic [11:0] blink_v;
    int exp_off[6] = '{0, 10, 14, 18, 22, 26};

    initial begin
        reset = 1'b1; tick_1hz = 1'b0; btn_mode = 1'b0; btn_adjust = 1'b0;
        @(posedge clk);
        #1;
        cycles(3);

        // Reset release and one-shot load.
        reset = 1'b0;
        cycle();
        chk("load_pulse", 32'(load_new), 32'd1);
        chk("load_value", 32'(time_to_load_bcd), 32'h0012_0000);
        cycle();
        chk("load_once", 32'(load_new), 32'd0);
        chk("model_load_time", 32'(m_hh * 10000 + m_mm * 100 + m_ss), 32'd120000);
        cycles(2);
        chk("load_stays_low", 32'(load_new), 32'd0);

        // RUN carry at 23:59:59.
        m_hh = 23; m_mm = 59; m_ss = 59;
        clr_cnt();
        tick_1hz = 1'b1;
        cycle();
        tick_1hz = 1'b0;
        chk("carry_hours", 32'(cnt_h), 32'd1);
        chk("carry_minutes", 32'(cnt_m), 32'd1);
        chk("carry_seconds", 32'(cnt_s), 32'd1);
        chk("carry_time", 32'(m_hh * 10000 + m_mm * 100 + m_ss), 32'd0);
        cycle();

        // RUN at 12:34:56: seconds only.
        m_hh = 12; m_mm = 34; m_ss = 56;
        clr_cnt();
        tick_1hz = 1'b1;
        cycle();
        tick_1hz = 1'b0;
        cycle();
        chk("tick_hours", 32'(cnt_h), 32'd0);
        chk("tick_minutes", 32'(cnt_m), 32'd0);
        chk("tick_seconds", 32'(cnt_s), 32'd1);

        // SET_HOURS with three adjust presses, then frozen ticks.
        btn_mode = 1'b1;
        cycle();
        btn_mode = 1'b0;
        chk("set_hours_mode", 32'(set_mode), 32'd1);
        clr_cnt();
        for (int i = 0; i < 3; i++) begin
            btn_adjust = 1'b1;
            cycle();
            btn_adjust = 1'b0;
            cycles(2);
        end
        chk("set_hours_count", 32'(cnt_h), 32'd3);
        chk("set_hours_no_min", 32'(cnt_m), 32'd0);
        chk("set_hours_time", 32'(m_hh * 10000 + m_mm * 100 + m_ss), 32'd153457);
        for (int i = 0; i < 2; i++) begin
            tick_1hz = 1'b1;
            cycle();
            tick_1hz = 1'b0;
            cycles(2);
        end
        chk("set_hours_tick_frozen", 32'(cnt_s), 32'd0);

        // SET_MINUTES blink: 5 cycles visible, 5 blanked, ...
        btn_mode = 1'b1;
        cycle();
        btn_mode = 1'b0;
        chk("set_minutes_mode", 32'(set_mode), 32'd2);
        for (int i = 0; i < 12; i++) begin
            blink_v[i] = blank_minutes;
            cycle();
        end
        chk("blink_sequence", 32'(blink_v), 32'h3E0);
        cycles(3);
        chk("blink_phase_on", 32'(blank_minutes), 32'd1);
        btn_adjust = 1'b1;
        cycle();
        btn_adjust = 1'b0;
        chk("blink_adjust_clear", 32'(blank_minutes), 32'd0);
        cycles(4);
        chk("blink_restart_off", 32'(blank_minutes), 32'd0);
        cycle();
        chk("blink_restart_on", 32'(blank_minutes), 32'd1);
        chk("blink_hours_off", 32'(blank_hours), 32'd0);
        cycles(2);

        // Auto-repeat in SET_MINUTES across minute 59.
        m_mm = 57;
        clr_cnt();
        ev_q.delete();
        ev_base = cyc;
        rec_ev = 1'b1;
        btn_adjust = 1'b1;
        cycles(30);
        btn_adjust = 1'b0;
        rec_ev = 1'b0;
        cycle();
        chk("repeat_count", 32'(ev_q.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            chk("repeat_offset", (i < ev_q.size()) ? 32'(ev_q[i]) : 32'hFFFF_FFFF, 32'(exp_off[i]));
        chk("repeat_no_hours", 32'(cnt_h), 32'd0);
        chk("repeat_time", 32'(m_hh * 10000 + m_mm * 100 + m_ss), 32'd150357);

        // btn_mode and adjust in the same cycle: mode wins.
        clr_cnt();
        btn_mode = 1'b1;
        btn_adjust = 1'b1;
        cycle();
        btn_mode = 1'b0;
        btn_adjust = 1'b0;
        cycle();
        chk("mode_wins_state", 32'(set_mode), 32'd0);
        chk("mode_wins_no_inc", 32'(cnt_m + cnt_h), 32'd0);

        // Idle timeout in SET_HOURS.
        btn_mode = 1'b1;
        cycle();
        btn_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick_1hz = 1'b1;
            cycle();
            tick_1hz = 1'b0;
            cycle();
        end
        cycles(3);
        chk("timeout_state", 32'(set_mode), TMO_EN ? 32'd0 : 32'd1);

        // Reset during set mode with repeat running.
        btn_mode = 1'b1;
        cycle();
        btn_mode = 1'b0;
        btn_adjust = 1'b1;
        cycles(12);
        reset = 1'b1;
        cycles(2);
        chk("midreset_mode", 32'(set_mode), 32'd0);
        chk("midreset_blank", 32'({blank_hours, blank_minutes}), 32'd0);
        chk("midreset_load", 32'(load_new), 32'd0);
        reset = 1'b0;
        cycle();
        chk("reload_pulse", 32'(load_new), 32'd1);
        cycle();
        chk("reload_once", 32'(load_new), 32'd0);
        btn_adjust = 1'b0;
        cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
